operand_fetch: RTL and testbench
================================

# operand_fetch

Operand fetch sequencer that reads the source registers of one instruction through the single combinational read port of the register file. It sits between decode and execute:
- takes rs1/rs2 indices with a valid/ready handshake;
- drives the register file read address for one cycle per operand;
- returns both operand values to execute with a second valid/ready handshake.

It also snoops the register file write port so that operands never miss a write landing on the same edge.

## Interface
Parameters:
- none; datapath width is `XLEN` from defines.v.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  decode presents a fetch request.
- req_ready  out  1  request accepted on the edge where `req_valid & req_ready`.
- req_rs1  in  5  first source register index.
- req_rs2  in  5  second source register index.
- req_need_rs2  in  1  0 = single-operand instruction; rs2 is not read.
- rf_read_addr  out  5  register file read address.
- rf_read_data  in  XLEN  register file read data, combinational from rf_read_addr.
- rf_write  in  1  snoop of register file write enable.
- rf_write_addr  in  5  snoop of register file write address.
- rf_write_data  in  XLEN  snoop of register file write data.
- op_valid  out  1  operands valid; held until accepted.
- op_ready  in  1  execute accepts operands on the edge where `op_valid & op_ready`.
- op_rs1_data  out  XLEN  rs1 value.
- op_rs2_data  out  XLEN  rs2 value; 0 when req_need_rs2 = 0.

## Operation
- FSM states: IDLE, RD1, RD2, DONE.
- IDLE: req_ready = 1 and rf_read_addr = 0. On accept, latch rs1, rs2 and need_rs2, then go to RD1.
- RD1: rf_read_addr = rs1. At the edge, capture rs1_data. Next state is RD2 if need_rs2, otherwise DONE with rs2_data = 0.
- RD2: rf_read_addr = rs2. At the edge, capture rs2_data, then go to DONE.
- DONE: op_valid = 1 and rf_read_addr = 0.
  - req_ready = op_ready, so this is a combinational path from op_ready to req_ready.
  - On `op_ready & req_valid`: hand off the operands and accept the new request in the same edge; next state is RD1.
  - On `op_ready` without a request: go to IDLE.
- Index 0 always captures 0, regardless of rf_read_data and of any snooped write.
- Captured data and latched indices are held unchanged while op_valid = 1 and op_ready = 0, subject to the bypass updates under Configuration.
- Reset, including mid-operation, is asynchronous:
  - state goes to IDLE;
  - op_valid = 0;
  - op_rs1_data and op_rs2_data = 0;
  - latched indices = 0;
  - the in-flight request is discarded.

## Timing
- Reset values: op_valid 0, op_rs1_data 0, op_rs2_data 0, rf_read_addr 0. req_ready is 1 once state is IDLE.
- Latency with need_rs2 = 1:
  - accept at edge E;
  - rs1 captured at E+1;
  - rs2 captured at E+2;
  - op_valid high from E+2 (first visible in cycle E+2..E+3).
- Latency with need_rs2 = 0: op_valid is high from E+1.
- Throughput with op_ready held at 1:
  - one instruction per 3 cycles with need_rs2 = 1;
  - one per 2 cycles with need_rs2 = 0.
- No combinational path from req_* to op_*. op_* outputs are registered or decoded from state.

## Configuration
- Macro: `OPERAND_FETCH_BYPASS_EN`.
- Defined, same-edge bypass:
  - In RD1 or RD2, if `rf_write` is high, `rf_write_addr` equals the index being read, and the index ≠ 0, capture `rf_write_data` instead of `rf_read_data`.
  - This covers the write landing on the same edge as the read.
- Defined, held-operand update:
  - In RD2 and DONE, any snooped write with `rf_write_addr` equal to a nonzero, already-captured index overwrites that held operand at the same edge.
  - This applies to rs1, and to rs2 when need_rs2 = 1.
  - Operands therefore always equal the register file contents at the moment of handoff.
- Undefined: operands are captured only from `rf_read_data` and are never updated afterwards. The pipeline is responsible for hazards.

## Test plan
- Reset, then req rs1=5, rs2=6, need_rs2=1, with x5=0x11 and x6=0x22 preloaded → op_valid high 2 edges after accept; op_rs1_data = 0x11, op_rs2_data = 0x22.
- need_rs2 = 0 with rs1 = 7 (x7 = 0xAB) → op_valid 1 edge after accept; op_rs2_data = 0; rf_read_addr is never 0 during RD1 and never shows rs2.
- rs1 = 0 and rs2 = 0, with a snooped write to address 0 of 0xFF → both operands = 0.
- op_ready low for 5 cycles, then high together with req_valid → operands stable throughout the stall; the new request is accepted on the handoff edge; state goes to RD1 without passing through IDLE.
- Bypass on:
  - write x6 = 0x99 on the RD2 edge → op_rs2_data = 0x99;
  - write x5 = 0x77 during DONE → op_rs1_data = 0x77;
  - bypass off → old values 0x22 and 0x11.
- Assert rstn low during RD2 → op_valid = 0 and both operands = 0 immediately, with no clock edge required; after release, req_ready = 1 and the next request completes normally.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: reads rs1/rs2 through the single register file read port and hands both operands to execute; define OPERAND_FETCH_BYPASS_EN to snoop register file writes into captured operands
`ifndef XLEN
`define XLEN 32
`endif
module operand_fetch (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic             req_need_rs2,
  output logic [4:0]       rf_read_addr,
  input  logic [`XLEN-1:0] rf_read_data,
  input  logic             rf_write,
  input  logic [4:0]       rf_write_addr,
  input  logic [`XLEN-1:0] rf_write_data,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [`XLEN-1:0] op_rs1_data,
  output logic [`XLEN-1:0] op_rs2_data
);
  typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} state_e;
  state_e state_q, state_d;
  logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic need_q, need_d;
  logic [`XLEN-1:0] d1_q, d1_d, d2_q, d2_d, cap;
`ifdef OPERAND_FETCH_BYPASS_EN
  logic hit1, hit2;
  assign hit1 = rf_write && rf_write_addr == rs1_q && rs1_q != 5'd0;
  assign hit2 = rf_write && rf_write_addr == rs2_q && rs2_q != 5'd0 && need_q;
`else
  logic unused_snoop;
  assign unused_snoop = ^{rf_write, rf_write_addr, rf_write_data};
`endif
  assign op_valid    = state_q == DONE;
  assign op_rs1_data = d1_q;
  assign op_rs2_data = d2_q;
  // Read address per state and the value captured this edge; x0 always reads as zero
  always_comb begin
    rf_read_addr = state_q == RD1 ? rs1_q : state_q == RD2 ? rs2_q : 5'd0;
`ifdef OPERAND_FETCH_BYPASS_EN
    cap = rf_read_addr == 5'd0 ? '0 : (rf_write && rf_write_addr == rf_read_addr) ? rf_write_data : rf_read_data;
`else
    cap = rf_read_addr == 5'd0 ? '0 : rf_read_data;
`endif
  end
  // Next state, operand capture and handshakes; DONE may hand off and accept on the same edge
  always_comb begin
    state_d   = state_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    need_d    = need_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    req_ready = state_q == IDLE || (state_q == DONE && op_ready);
`ifdef OPERAND_FETCH_BYPASS_EN
    if ((state_q == RD2 || state_q == DONE) && hit1) d1_d = rf_write_data;
    if (state_q == DONE && hit2) d2_d = rf_write_data;
`endif
    if (state_q == RD1) begin
      d1_d    = cap;
      d2_d    = '0;
      state_d = need_q ? RD2 : DONE;
    end
    if (state_q == RD2) begin
      d2_d    = cap;
      state_d = DONE;
    end
    if (state_q == DONE && op_ready) state_d = IDLE;
    if (req_valid && req_ready) begin
      rs1_d   = req_rs1;
      rs2_d   = req_rs2;
      need_d  = req_need_rs2;
      state_d = RD1;
    end
  end
  // State and operand registers with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      need_q  <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      need_q  <= need_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: vector table, directed corner sequences and a randomized transaction-level model for operand_fetch
`ifndef XLEN
`define XLEN 32
`endif
module tb_operand_fetch;
  localparam int W = `XLEN;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_need_rs2 = 1'b0;
  logic [4:0] req_rs1 = '0, req_rs2 = '0, rf_read_addr, rf_write_addr = '0;
  logic [W-1:0] rf_read_data, rf_write_data = '0, op_rs1_data, op_rs2_data;
  logic rf_write = 1'b0, op_valid, op_ready = 1'b0;
  logic [W-1:0] regs [32];
  int errs = 0, checks = 0;

  operand_fetch dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_need_rs2(req_need_rs2),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write(rf_write), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data)
  );

  always #5 clk = ~clk;
  assign rf_read_data = regs[rf_read_addr];
  always @(posedge clk) if (rf_write) regs[rf_write_addr] <= rf_write_data;

  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  typedef struct {
    logic [4:0] rs1, rs2;
    logic need, wr_x0;
    logic [W-1:0] e1, e2;
  } vec_t;

  // One full transaction from IDLE, checking per-cycle read address and latency
  task automatic run_vec(input vec_t v);
    req_valid = 1; req_rs1 = v.rs1; req_rs2 = v.rs2; req_need_rs2 = v.need; op_ready = 0;
    rf_write = v.wr_x0; rf_write_addr = 0; rf_write_data = 'hFF;
    #1 chk("idle_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0; req_rs1 = 5'd31; req_rs2 = 5'd31;
    chk("rd1_addr", rf_read_addr, v.rs1);
    chk("rd1_valid", op_valid, 0);
    @(negedge clk);
    if (v.need) begin
      chk("rd2_addr", rf_read_addr, v.rs2);
      chk("rd2_valid", op_valid, 0);
      @(negedge clk);
    end
    rf_write = 0;
    chk("done_valid", op_valid, 1);
    chk("done_addr", rf_read_addr, 0);
    chk("done_ready_low", req_ready, 0);
    chk("rs1_data", op_rs1_data, v.e1);
    chk("rs2_data", op_rs2_data, v.e2);
    op_ready = 1;
    #1 chk("done_ready_pass", req_ready, 1);
    @(negedge clk);
    op_ready = 0;
    chk("back_idle", op_valid, 0);
  endtask

  vec_t vecs [6];
  bit have, t_need;
  int cyc, acc;
  logic [4:0] t1, t2;
  logic [W-1:0] v1, v2, e1, e2;
  logic exp_valid, exp_rdy;
  logic [4:0] exp_addr;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 'hFF; regs[5] = 'h11; regs[6] = 'h22; regs[7] = 'hAB;
    vecs[0] = '{5'd5, 5'd6, 1'b1, 1'b0, 'h11, 'h22};
    vecs[1] = '{5'd7, 5'd3, 1'b0, 1'b0, 'hAB, 0};
    vecs[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 0, 0};
    vecs[3] = '{5'd0, 5'd6, 1'b1, 1'b1, 0, 'h22};
    vecs[4] = '{5'd7, 5'd0, 1'b1, 1'b0, 'hAB, 0};
    vecs[5] = '{5'd6, 5'd5, 1'b1, 1'b0, 'h22, 'h11};
    @(negedge clk); @(negedge clk);
    chk("rst_valid", op_valid, 0);
    chk("rst_rs1", op_rs1_data, 0);
    chk("rst_rs2", op_rs2_data, 0);
    chk("rst_addr", rf_read_addr, 0);
    rstn = 1;
    #1 chk("rst_ready", req_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Stall with op_ready low, then back-to-back handoff and accept
    req_valid = 1; req_rs1 = 5; req_rs2 = 6; req_need_rs2 = 1;
    @(negedge clk); req_valid = 0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", op_valid, 1);
      chk("stall_rs1", op_rs1_data, 'h11);
      chk("stall_rs2", op_rs2_data, 'h22);
      @(negedge clk);
    end
    op_ready = 1; req_valid = 1; req_rs1 = 7; req_need_rs2 = 0;
    #1 chk("b2b_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    chk("b2b_rd1_valid", op_valid, 0);
    chk("b2b_rd1_addr", rf_read_addr, 7);
    @(negedge clk);
    chk("b2b_valid", op_valid, 1);
    chk("b2b_rs1", op_rs1_data, 'hAB);
    chk("b2b_rs2", op_rs2_data, 0);
    @(negedge clk);
    op_ready = 0;

    // Write on the RD2 edge and while holding in DONE
    req_valid = 1; req_rs1 = 5; req_rs2 = 6; req_need_rs2 = 1;
    @(negedge clk); req_valid = 0;
    @(negedge clk);
    rf_write = 1; rf_write_addr = 6; rf_write_data = 'h99;
    @(negedge clk);
    rf_write = 0;
    chk("byp_rs2", op_rs2_data, BYP ? 'h99 : 'h22);
    rf_write = 1; rf_write_addr = 5; rf_write_data = 'h77;
    @(negedge clk);
    rf_write = 0;
    chk("byp_rs1", op_rs1_data, BYP ? 'h77 : 'h11);
    chk("byp_rs2_hold", op_rs2_data, BYP ? 'h99 : 'h22);
    op_ready = 1;
    @(negedge clk);
    op_ready = 0;
    regs[5] = 'h11; regs[6] = 'h22;

    // Asynchronous reset while in RD2
    req_valid = 1; req_rs1 = 5; req_rs2 = 6; req_need_rs2 = 1;
    @(negedge clk); req_valid = 0;
    @(negedge clk);
    #2 rstn = 0;
    #1;
    chk("arst_valid", op_valid, 0);
    chk("arst_rs1", op_rs1_data, 0);
    chk("arst_rs2", op_rs2_data, 0);
    chk("arst_addr", rf_read_addr, 0);
    @(negedge clk);
    rstn = 1;
    #1 chk("arst_ready", req_ready, 1);
    @(negedge clk);
    run_vec(vecs[0]);

    // Randomized traffic against a transaction-level model
    have = 0; cyc = 0; acc = 0;
    for (int k = 0; k < 400; k++) begin
      req_valid = $urandom_range(0, 2) != 0;
      req_rs1 = 5'($urandom_range(0, 7));
      req_rs2 = 5'($urandom_range(0, 7));
      req_need_rs2 = 1'($urandom_range(0, 1));
      op_ready = $urandom_range(0, 3) != 0;
      rf_write = 1'($urandom_range(0, 1));
      rf_write_addr = 5'($urandom_range(0, 7));
      rf_write_data = $urandom;
      #1;
      exp_valid = have && cyc >= acc + (t_need ? 2 : 1);
      exp_rdy = !have || (exp_valid && op_ready);
      exp_addr = (have && cyc == acc) ? t1 : (have && t_need && cyc == acc + 1) ? t2 : 5'd0;
      chk("rnd_valid", op_valid, exp_valid);
      chk("rnd_ready", req_ready, exp_rdy);
      chk("rnd_addr", rf_read_addr, exp_addr);
      if (have && cyc == acc) v1 = t1 == 0 ? '0 : regs[t1];
      if (have && t_need && cyc == acc + 1) v2 = t2 == 0 ? '0 : regs[t2];
      if (exp_valid && op_ready) begin
        e1 = BYP ? (t1 == 0 ? '0 : regs[t1]) : v1;
        e2 = !t_need ? '0 : BYP ? (t2 == 0 ? '0 : regs[t2]) : v2;
        chk("rnd_rs1", op_rs1_data, e1);
        chk("rnd_rs2", op_rs2_data, e2);
        have = 0;
      end
      if (req_valid && exp_rdy) begin
        have = 1; acc = cyc + 1; t1 = req_rs1; t2 = req_rs2; t_need = req_need_rs2;
      end
      @(negedge clk);
      cyc++;
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
